sr_lock_arbiter: RTL and testbench

Round-robin arbiter granting one shared storage resource (an SR flag bank or similar single-owner datapath element) to one of several requesters at a time. It replaces ad-hoc preset/clear wiring with a clocked grant/release handshake, a bounded hold time and a guard cycle between owners. It sits between the requesting control units and the shared element, and drives that element's select/enable from its one-hot grant.

---
 rtl/sr_lock_arbiter_pkg.sv | 28 ++
 rtl/sr_lock_arbiter_picker.sv | 51 +++++
 rtl/sr_lock_arbiter.sv | 154 +++++++++++++++
 tb/tb_sr_lock_arbiter.sv | 156 +++++++++++++++
 4 files changed

// File: rtl/sr_lock_arbiter_pkg.sv
// sr_lock_arbiter_pkg
//   Shared definitions for the lock arbiter and its picker:
//   - state_e   : FSM encodings IDLE=0, GRANTED=1, RELEASE=2 (3 is illegal
//                 and recovers to IDLE)
//   - owner_width(n) : index width for n requesters, minimum 1
//   - count_width(h) : hold-counter width able to hold h, minimum 1
`ifndef SR_LOCK_ARBITER_PKG_SV
`define SR_LOCK_ARBITER_PKG_SV

package sr_lock_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_GRANTED = 2'd1,
    ST_RELEASE = 2'd2
  } state_e;

  function automatic int owner_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  function automatic int count_width(input int h);
    return (h <= 1) ? 1 : $clog2(h + 1);
  endfunction

endpackage

`endif

// File: rtl/sr_lock_arbiter_picker.sv
// round_robin_picker
//   Combinational round-robin search. The winner is the first set request
//   bit strictly above pointer; if none exists the search wraps to the
//   lowest set bit overall.
//   Ports:
//     request     in  N   request vector
//     pointer     in  OW  index of the previous winner
//     winner      out N   one-hot winner (all-zero when no request)
//     winner_idx  out OW  binary index of winner
//     any_request out 1   OR of request
module round_robin_picker
  import sr_lock_arbiter_pkg::*;
#(
  parameter int N  = 4,
  parameter int OW = owner_width(N)
) (
  input  logic [N-1:0]  request,
  input  logic [OW-1:0] pointer,
  output logic [N-1:0]  winner,
  output logic [OW-1:0] winner_idx,
  output logic          any_request
);

  localparam logic [N-1:0] ONE = N'(1);

  logic [N-1:0] upper_mask;
  logic [N-1:0] upper_req;
  logic [N-1:0] search;

  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_mask
      assign upper_mask[gi] = (OW'(gi) > pointer);
    end
  endgenerate

  // Prefer requests above the pointer; fall back to the full vector (wrap).
  assign upper_req   = request & upper_mask;
  assign search      = (|upper_req) ? upper_req : request;
  // Isolate the lowest set bit.
  assign winner      = search & (~search + ONE);
  assign any_request = |request;

  always_comb begin
    winner_idx = '0;
    for (int i = 0; i < N; i++) begin
      if (winner[i]) winner_idx = winner_idx | OW'(i);
    end
  end

endmodule

// File: rtl/sr_lock_arbiter.sv
// sr_lock_arbiter
//   Round-robin single-owner lock for a shared storage element. A winner is
//   registered from IDLE, holds the grant in GRANTED until it releases,
//   drops its request or exhausts HOLD_LIMIT cycles, then the arbiter spends
//   one RELEASE guard cycle with no grant before returning to IDLE.
//   Ports:
//     clock          in  1         rising-edge clock
//     clear_negated  in  1         asynchronous active-low reset
//     request        in  REQ       level request per requester
//     release_pulse  in  REQ       one-cycle release pulse per requester
//     grant          out REQ       registered one-hot grant
//     grant_valid    out 1         OR of grant
//     owner          out OW        index of current or last owner
//     timeout_pulse  out 1         one-cycle pulse on hold-limit revocation
module sr_lock_arbiter
  import sr_lock_arbiter_pkg::*;
#(
  parameter int REQUESTERS = 4,
  parameter int HOLD_LIMIT = 15
) (
  input  logic                                 clock,
  input  logic                                 clear_negated,
  input  logic [REQUESTERS-1:0]                request,
  input  logic [REQUESTERS-1:0]                release_pulse,
  output logic [REQUESTERS-1:0]                grant,
  output logic                                 grant_valid,
  output logic [owner_width(REQUESTERS)-1:0]   owner,
  output logic                                 timeout_pulse
);

  localparam int OW = owner_width(REQUESTERS);
  localparam int CW = count_width(HOLD_LIMIT);

  localparam logic [CW-1:0] COUNT_ONE    = CW'(1);
  localparam logic [CW-1:0] COUNT_MAX    = CW'(HOLD_LIMIT);
  // Compare one below the limit so the grant is visible for exactly
  // HOLD_LIMIT cycles (counter reads 0 in the first granted cycle).
  localparam logic [CW-1:0] COUNT_LAST   = (HOLD_LIMIT == 0) ? '0 : CW'(HOLD_LIMIT - 1);
  localparam logic [OW-1:0] POINTER_INIT = OW'(REQUESTERS - 1);

  state_e                  state_reg, state_next;
  logic [REQUESTERS-1:0]   grant_reg, grant_next;
  logic [OW-1:0]           owner_reg, owner_next;
  logic [OW-1:0]           pointer_reg, pointer_next;
  logic [CW-1:0]           count_reg, count_next;
  logic                    timeout_reg, timeout_next;

  logic [REQUESTERS-1:0]   pick_onehot;
  logic [OW-1:0]           pick_idx;
  logic                    pick_any;

  logic                    own_release;
  logic                    own_dropped;
  logic                    hold_expired;

  round_robin_picker #(
    .N  (REQUESTERS),
    .OW (OW)
  ) u_picker (
    .request     (request),
    .pointer     (pointer_reg),
    .winner      (pick_onehot),
    .winner_idx  (pick_idx),
    .any_request (pick_any)
  );

  // Only the owner's own lines matter while granted.
  assign own_release  = release_pulse[owner_reg];
  assign own_dropped  = ~request[owner_reg];
  assign hold_expired = (HOLD_LIMIT != 0) && (count_reg == COUNT_LAST);

  // State register
  always_ff @(posedge clock or negedge clear_negated) begin
    if (!clear_negated) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE:    if (pick_any) state_next = ST_GRANTED;
      ST_GRANTED: if (own_release || own_dropped || hold_expired) state_next = ST_RELEASE;
      ST_RELEASE: state_next = ST_IDLE;
      default:    state_next = ST_IDLE;
    endcase
  end

  // Output / datapath next values
  always_comb begin
    grant_next   = grant_reg;
    owner_next   = owner_reg;
    pointer_next = pointer_reg;
    count_next   = count_reg;
    timeout_next = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (pick_any) begin
          grant_next   = pick_onehot;
          owner_next   = pick_idx;
          pointer_next = pick_idx;
          count_next   = '0;
        end else begin
          grant_next = '0;
        end
      end
      ST_GRANTED: begin
        if (count_reg != COUNT_MAX) count_next = count_reg + COUNT_ONE;
        // A voluntary exit wins over the timeout, so the pulse only fires
        // when the limit alone ends the grant.
        if (own_release || own_dropped) begin
          grant_next = '0;
        end else if (hold_expired) begin
          grant_next   = '0;
          timeout_next = 1'b1;
        end
      end
      ST_RELEASE: begin
        grant_next = '0;
        count_next = '0;
      end
      default: begin
        grant_next = '0;
        count_next = '0;
      end
    endcase
  end

  // Output and datapath registers
  always_ff @(posedge clock or negedge clear_negated) begin
    if (!clear_negated) begin
      grant_reg   <= '0;
      owner_reg   <= '0;
      pointer_reg <= POINTER_INIT;
      count_reg   <= '0;
      timeout_reg <= 1'b0;
    end else begin
      grant_reg   <= grant_next;
      owner_reg   <= owner_next;
      pointer_reg <= pointer_next;
      count_reg   <= count_next;
      timeout_reg <= timeout_next;
    end
  end

  assign grant         = grant_reg;
  assign grant_valid   = |grant_reg;
  assign owner         = owner_reg;
  assign timeout_pulse = timeout_reg;

endmodule

// File: tb/tb_sr_lock_arbiter.sv
// tb_sr_lock_arbiter
//   Directed bench for sr_lock_arbiter (4 requesters, HOLD_LIMIT 15):
//   a cycle-by-cycle vector table for rotation and non-owner noise, then
//   hand-written sequences for timeout, release/timeout collision and
//   asynchronous mid-grant reset.
module tb_sr_lock_arbiter;

  logic       clock = 1'b0;
  logic       clear_negated;
  logic [3:0] request;
  logic [3:0] release_pulse;
  logic [3:0] grant;
  logic       grant_valid;
  logic [1:0] owner;
  logic       timeout_pulse;

  int total_checks = 0;
  int passed_checks = 0;

  sr_lock_arbiter #(
    .REQUESTERS (4),
    .HOLD_LIMIT (15)
  ) dut (
    .clock         (clock),
    .clear_negated (clear_negated),
    .request       (request),
    .release_pulse (release_pulse),
    .grant         (grant),
    .grant_valid   (grant_valid),
    .owner         (owner),
    .timeout_pulse (timeout_pulse)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [3:0] req;
    logic [3:0] rel;
    logic [3:0] exp_grant;
    logic [1:0] exp_owner;
  } vec_t;

  localparam int NVEC = 24;
  vec_t vecs [NVEC];

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_checks++;
    if (act === exp) begin
      passed_checks++;
    end else begin
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic check_outputs(input string tag, input logic [3:0] g, input logic [1:0] o,
                               input logic t);
    check({tag, " grant"}, 32'(grant), 32'(g));
    check({tag, " grant_valid"}, 32'(grant_valid), 32'(|g));
    check({tag, " owner"}, 32'(owner), 32'(o));
    check({tag, " timeout"}, 32'(timeout_pulse), 32'(t));
  endtask

  initial begin
    // Cycle-by-cycle table: inputs applied, one clock, outputs checked.
    // Two zero-grant cycles follow each exit (RELEASE, then IDLE).
    vecs[0]  = '{4'b1111, 4'b0000, 4'b0001, 2'd0};
    vecs[1]  = '{4'b1111, 4'b0001, 4'b0000, 2'd0};
    vecs[2]  = '{4'b1111, 4'b0000, 4'b0000, 2'd0};
    vecs[3]  = '{4'b1111, 4'b0000, 4'b0010, 2'd1};
    vecs[4]  = '{4'b1111, 4'b0010, 4'b0000, 2'd1};
    vecs[5]  = '{4'b1111, 4'b0000, 4'b0000, 2'd1};
    vecs[6]  = '{4'b1111, 4'b0000, 4'b0100, 2'd2};
    vecs[7]  = '{4'b1111, 4'b0100, 4'b0000, 2'd2};
    vecs[8]  = '{4'b1111, 4'b0000, 4'b0000, 2'd2};
    vecs[9]  = '{4'b1111, 4'b0000, 4'b1000, 2'd3};
    vecs[10] = '{4'b1111, 4'b1000, 4'b0000, 2'd3};
    vecs[11] = '{4'b1111, 4'b0000, 4'b0000, 2'd3};
    vecs[12] = '{4'b1111, 4'b0000, 4'b0001, 2'd0};
    vecs[13] = '{4'b1111, 4'b0001, 4'b0000, 2'd0};
    vecs[14] = '{4'b1111, 4'b0000, 4'b0000, 2'd0};
    vecs[15] = '{4'b1111, 4'b0000, 4'b0010, 2'd1};
    // Non-owner noise: release on 3,2,0 and request[3] dropped.
    vecs[16] = '{4'b0111, 4'b1101, 4'b0010, 2'd1};
    vecs[17] = '{4'b0111, 4'b0000, 4'b0010, 2'd1};
    // Owner drops its own request.
    vecs[18] = '{4'b0101, 4'b0000, 4'b0000, 2'd1};
    vecs[19] = '{4'b0101, 4'b0000, 4'b0000, 2'd1};
    vecs[20] = '{4'b0101, 4'b0000, 4'b0100, 2'd2};
    vecs[21] = '{4'b0101, 4'b0100, 4'b0000, 2'd2};
    vecs[22] = '{4'b0000, 4'b0000, 4'b0000, 2'd2};
    vecs[23] = '{4'b0000, 4'b0000, 4'b0000, 2'd2};

    // Reset held with all requests active.
    clear_negated = 1'b0;
    request       = 4'b1111;
    release_pulse = 4'b0000;
    step();
    step();
    check_outputs("reset", 4'b0000, 2'd0, 1'b0);
    clear_negated = 1'b1;

    for (int i = 0; i < NVEC; i++) begin
      request       = vecs[i].req;
      release_pulse = vecs[i].rel;
      step();
      check_outputs($sformatf("vec%0d", i), vecs[i].exp_grant, vecs[i].exp_owner, 1'b0);
    end

    // Timeout: request 0100 held, no release.
    request       = 4'b0100;
    release_pulse = 4'b0000;
    step();
    for (int i = 0; i < 15; i++) begin
      check_outputs($sformatf("hold%0d", i), 4'b0100, 2'd2, 1'b0);
      step();
    end
    check_outputs("timeout_drop", 4'b0000, 2'd2, 1'b1);
    step();
    check_outputs("timeout_idle", 4'b0000, 2'd2, 1'b0);
    step();
    check_outputs("timeout_regrant", 4'b0100, 2'd2, 1'b0);

    // Release on the final hold cycle: release wins, no timeout pulse.
    for (int i = 0; i < 14; i++) step();
    check_outputs("collide_last_hold", 4'b0100, 2'd2, 1'b0);
    release_pulse = 4'b0100;
    step();
    release_pulse = 4'b0000;
    check_outputs("collide_drop", 4'b0000, 2'd2, 1'b0);

    // Mid-grant asynchronous reset while requester 3 owns the lock.
    request = 4'b1000;
    step();
    step();
    check_outputs("pre_reset_grant", 4'b1000, 2'd3, 1'b0);
    request = 4'b1001;
    #2;
    clear_negated = 1'b0;
    #1;
    check_outputs("async_reset", 4'b0000, 2'd0, 1'b0);
    step();
    check_outputs("reset_hold", 4'b0000, 2'd0, 1'b0);
    clear_negated = 1'b1;
    step();
    check_outputs("post_reset_grant", 4'b0001, 2'd0, 1'b0);

    $display("%0d/%0d checks passed", passed_checks, total_checks);
    $finish;
  end

endmodule
